// File: rtl/vr_arb_pkg.sv
// Shared types and defaults for the packet-granular valid-ready arbiter.
package vr_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_IN = 4;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/vr_packet_arbiter_rr_pick.sv
// Combinational round-robin search: first requester after last_grant, wrapping.
module rr_pick #(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic              any,
  output logic [IDX_W-1:0]  idx
);

  logic [NUM_IN-1:0] win;
  int                base;
  int                pos;
  int                sel;

  // Rotating the doubled request vector puts last_grant+1 at bit 0, so the
  // lowest set bit of the window is the round-robin winner.
  always_comb begin
    base = int'(last_grant) + 1;
    win  = NUM_IN'({req, req} >> base);
    pos  = 0;
    for (int j = NUM_IN - 1; j >= 0; j--) begin
      if (win[j]) pos = j;
    end
    sel = base + pos;
    if (sel >= NUM_IN) sel = sel - NUM_IN;
    any = |req;
    idx = IDX_W'(sel);
  end

endmodule

// File: rtl/vr_packet_arbiter.sv
// Round-robin arbiter that locks a requester onto the FIFO write port until its last beat.
module vr_packet_arbiter
  import vr_arb_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = ($clog2(NUM_IN) > 0 ? $clog2(NUM_IN) : 1)
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     en,
  input  logic                     sync_rst,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_last,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_src,
  output logic                     busy
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             locked;
  logic             pkt_done;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req        (in_valid),
    .last_grant (last_grant_q),
    .any        (pick_any),
    .idx        (pick_idx)
  );

  assign locked  = (state_q == ARB_LOCKED);
  assign busy    = locked;
  assign out_src = grant_q;

  // Pass-through mux; only the ready path from out_ready is combinational.
  always_comb begin
    out_data  = in_data[int'(grant_q) * DATA_W +: DATA_W];
    out_last  = in_last[grant_q];
    out_valid = en & locked & in_valid[grant_q];
    in_ready  = '0;
    if (en && locked) in_ready[grant_q] = out_ready;
    pkt_done  = out_valid & out_ready & out_last;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    if (en) begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_d = pick_idx;
            state_d = ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (pkt_done) begin
            last_grant_d = grant_q;
            state_d      = ARB_IDLE;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_IN - 1);
    end else if (sync_rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_IN - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_vr_packet_arbiter.sv
// Randomized bench for vr_packet_arbiter against a packet-level round-robin model.
module tb_vr_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            nrst;
  logic            en;
  logic            sync_rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_src;
  logic            busy;

  always #5 clk = ~clk;

  vr_packet_arbiter #(.NUM_IN(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .sync_rst  (sync_rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .busy      (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  // Requester sources: a beat is offered until accepted, then the next beat follows.
  bit src_v[N];
  int src_beat[N];
  int src_len[N];
  int src_pkt[N];
  bit active[N];

  // Reference model: owner of the port (-1 when free), last winner, shown index.
  int m_own;
  int m_last;
  int m_grant;

  int  len_mode;
  int  p_valid, p_ready, p_en, p_rst, p_drain;
  bit  force_rst;
  bit  fifo_mode;
  int  fifo_cnt;
  bit  exp_valid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int new_len();
    return (len_mode == 0) ? 1 + int'($urandom_range(3)) : len_mode;
  endfunction

  function automatic logic [DW-1:0] beat_data(input int i);
    return {8'(i), 8'(src_pkt[i]), 16'(src_beat[i])};
  endfunction

  task automatic model_reset();
    m_own   = -1;
    m_last  = N - 1;
    m_grant = 0;
  endtask

  task automatic set_active(input bit a0, input bit a1, input bit a2, input bit a3);
    active[0] = a0; active[1] = a1; active[2] = a2; active[3] = a3;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!src_v[i] && active[i] && int'($urandom_range(99)) < p_valid) src_v[i] = 1'b1;
      in_valid[i]            = src_v[i];
      in_last[i]             = src_v[i] && (src_beat[i] == src_len[i] - 1);
      in_data[i*DW +: DW]    = beat_data(i);
    end
    en        = int'($urandom_range(99)) < p_en;
    sync_rst  = force_rst || (int'($urandom_range(99)) < p_rst);
    out_ready = fifo_mode ? (fifo_cnt < 4) : (int'($urandom_range(99)) < p_ready);
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_rdy;
    exp_rdy   = '0;
    exp_valid = (m_own >= 0) && en && src_v[m_own];
    if (m_own >= 0 && en) exp_rdy[m_own] = out_ready;
    chk("busy", 64'(busy), 64'(m_own >= 0));
    chk("out_src", 64'(out_src), 64'(m_grant));
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (exp_valid) begin
      chk("out_data", 64'(out_data), 64'(beat_data(m_own)));
      chk("out_last", 64'(out_last), 64'(src_beat[m_own] == src_len[m_own] - 1));
    end
  endtask

  task automatic step_model();
    bit hs;
    bit is_last;
    bit found;
    hs      = exp_valid && out_ready;
    is_last = 1'b0;
    if (hs) begin
      is_last        = (src_beat[m_own] == src_len[m_own] - 1);
      src_v[m_own]   = 1'b0;
      if (is_last) begin
        src_beat[m_own] = 0;
        src_pkt[m_own]++;
        src_len[m_own]  = new_len();
      end else begin
        src_beat[m_own]++;
      end
      if (fifo_mode) fifo_cnt++;
    end
    if (sync_rst) begin
      model_reset();
    end else if (en) begin
      if (m_own < 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!found && src_v[(m_last + k) % N]) begin
            found   = 1'b1;
            m_own   = (m_last + k) % N;
            m_grant = m_own;
          end
        end
      end else if (hs && is_last) begin
        m_last = m_own;
        m_own  = -1;
      end
    end
    if (fifo_mode && fifo_cnt > 0 && int'($urandom_range(99)) < p_drain) fifo_cnt--;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      check_outputs();
      step_model();
    end
  endtask

  // Asynchronous reset applied between edges; en held low until the next drive.
  task automatic async_reset();
    #1;
    nrst     = 1'b0;
    en       = 1'b0;
    sync_rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    nrst = 1'b0; en = 1'b0; sync_rst = 1'b0; out_ready = 1'b0;
    in_data = '0; in_last = '0; in_valid = '0;
    force_rst = 1'b0; fifo_mode = 1'b0; fifo_cnt = 0;
    p_valid = 100; p_ready = 100; p_en = 100; p_rst = 0; p_drain = 0;
    len_mode = 3;
    for (int i = 0; i < N; i++) begin
      src_v[i] = 1'b0; src_beat[i] = 0; src_pkt[i] = 0; src_len[i] = 3; active[i] = 1'b0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_reset();

    // Streams 0 and 2 contend right after reset with 3-beat packets.
    set_active(1, 0, 1, 0);
    run(12);

    // Continuous single-beat packets on all streams.
    len_mode = 1;
    for (int i = 0; i < N; i++) src_len[i] = 1;
    set_active(1, 1, 1, 1);
    run(18);

    // Lone stream 1, 4-beat packets, random backpressure.
    set_active(0, 0, 0, 0);
    run(4);
    len_mode = 4;
    set_active(0, 1, 0, 0);
    p_ready = 50;
    run(30);

    // Lone stream 3 with enable dropping in and out.
    set_active(0, 0, 0, 0);
    p_ready = 100;
    run(6);
    set_active(0, 0, 0, 1);
    p_en = 60;
    run(30);
    p_en = 100;
    set_active(0, 0, 0, 0);
    run(8);

    // Synchronous reset in the middle of a stream-2 packet while stream 0 waits.
    async_reset();
    set_active(0, 0, 1, 0);
    run(3);
    set_active(1, 0, 1, 0);
    force_rst = 1'b1;
    run(1);
    force_rst = 1'b0;
    run(14);

    // Sink behaves like a depth-4 FIFO, first stalled, then draining.
    len_mode = 0;
    set_active(1, 1, 1, 1);
    fifo_mode = 1'b1;
    fifo_cnt  = 0;
    p_drain   = 0;
    run(20);
    p_drain = 100;
    run(20);
    p_drain = 40;
    run(60);
    fifo_mode = 1'b0;

    // Fully random traffic with occasional enable gaps and local resets.
    p_valid = 60; p_ready = 70; p_en = 90; p_rst = 2;
    run(400);
    async_reset();
    p_rst = 0;
    run(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vr_packet_arbiter.md
Name: vr_packet_arbiter

Overview:
- Round-robin, packet-granular arbiter that shares one valid-ready FIFO write port between NUM_IN valid-ready requester streams.
- Once a requester is granted, it owns the output until its beat with last set completes a handshake. This keeps packets unbroken in the downstream FIFO.
- Sits directly upstream of the team's valid-ready FIFO and uses the same en / sync_rst / last conventions.

Parameters:
- NUM_IN, 4, number of requester streams (2..16).
- DATA_W, 32, data width per stream.
- IDX_W, ($clog2(NUM_IN) > 0 ? $clog2(NUM_IN) : 1), width of the grant index.

Ports:
- clk  input  1  clock.
- nrst  input  1  reset, asynchronous, active-low.
- en  input  1  block enable.
- sync_rst  input  1  synchronous local reset, same effect as nrst.
- in_data  input  NUM_IN*DATA_W  requester data; stream i occupies bits [i*DATA_W +: DATA_W].
- in_last  input  NUM_IN  per-stream end-of-packet flag.
- in_valid  input  NUM_IN  per-stream valid.
- in_ready  output  NUM_IN  per-stream ready.
- out_data  output  DATA_W  granted stream's data (to FIFO in_data).
- out_last  output  1  granted stream's last flag.
- out_valid  output  1  granted stream's valid.
- out_ready  input  1  FIFO in_ready.
- out_src  output  IDX_W  index of the currently granted stream.
- busy  output  1  high while in LOCKED.

Behaviour:
- Reset (nrst low, or sync_rst high at a clock edge):
  - state=IDLE, grant=0, last_grant=NUM_IN-1, so stream 0 has first priority.
  - All in_ready=0, out_valid=0, busy=0, out_src=0.
  - out_data/out_last are don't-care while out_valid=0; implementation drives stream grant's data.
- State machine (registered state, grant, last_grant):
  - IDLE:
    - If en=1 and |in_valid, set grant = first index with in_valid=1, searching last_grant+1, last_grant+2, ... modulo NUM_IN. Go to LOCKED.
    - Otherwise stay in IDLE.
  - LOCKED (combinational pass-through):
    - out_valid = in_valid[grant]; out_data/out_last = stream grant's signals.
    - in_ready[grant] = out_ready; every other in_ready = 0.
    - When out_valid & out_ready & out_last: last_grant <= grant, go to IDLE.
- Latency:
  - One cycle from a request in IDLE to out_valid.
  - One idle cycle between consecutive packets. Peak throughput is L/(L+1) beats per cycle for L-beat packets.
- Fairness: with all streams requesting continuously, grants rotate 0,1,2,3,0,... Worst-case wait for any stream is NUM_IN-1 packets.
- Single-beat packets (last on the first beat) are legal and follow the same flow.
- A granted stream dropping in_valid mid-packet (a bubble) keeps the lock; out_valid follows in_valid.
- en=0:
  - All in_ready=0, out_valid=0.
  - state, grant and last_grant hold. No handshake can occur, and the packet resumes when en returns.
- Reset mid-packet: returns to IDLE and the packet is truncated downstream. No recovery or flush; the system must reset the FIFO alongside.
- Simultaneous requests in IDLE resolve purely by round-robin order. A request arriving in the same cycle as grant registration waits.
- Requester obligation: once in_valid is high, data and last are held stable until handshake. The arbiter does not check this.
- No combinational path from in_valid to in_ready. There is a combinational path out_ready -> in_ready[grant].

Decomposition:
- Package vr_arb_pkg holds:
  - typedef arb_state_e {ARB_IDLE, ARB_LOCKED};
  - localparam default NUM_IN/DATA_W.
- One sub-module, rr_pick: combinational round-robin priority search.
  - Inputs: req[NUM_IN], last_grant[IDX_W].
  - Outputs: any, idx[IDX_W].
  - Implemented by doubled-vector masking.

Test Plan:
- Reset priority: after reset, streams 0 and 2 both present 3-beat packets at once, out_ready=1 → stream 0's 3 beats out first (out_src=0), 1 idle cycle, then stream 2's 3 beats (out_src=2).
- Rotation: all 4 streams hold 1-beat packets continuously for 8 grants → out_src sequence 0,1,2,3,0,1,2,3; each out_valid exactly 1 cycle after its grant.
- Backpressure mid-packet: stream 1 sends 4 beats (A0..A3, last on A3) while out_ready toggles 1,0,0,1,1,0,1 → exactly A0..A3 in order; in_ready[0,2,3]=0 throughout; no duplicates or drops.
- Enable gating: en=0 after beat 2 of a 4-beat packet on stream 3 for 5 cycles → in_ready and out_valid low for those 5 cycles; resumes with beat 3, and out_src stays 3.
- Reset mid-packet: sync_rst pulsed after beat 1 of a stream-2 packet while stream 0 also requests → next grant goes to stream 0 (last_grant=3 after reset); busy=0 on the cycle after the pulse.
- FIFO integration: arbiter feeds the team FIFO (DEPTH=4) with out_ready tied to FIFO in_ready and FIFO out_ready=0 → exactly 4 beats accepted and arbiter stalls; releasing out_ready drains all beats intact with last flags preserved.
